// File: rtl/vend_controller.sv
// vend_controller: main sequencing FSM for the vending machine.
// Collects coin credit, vends one item once credit reaches PRICE, then pays
// back change as one 5-unit coin per tick. All outputs are registered.
// Optional build macro: VEND_TIMEOUT_EN enables an auto-refund after
// TIMEOUT_TICKS ticks in COLLECT without an accepted coin.
module vend_controller #(
    parameter int PRICE         = 75,
    parameter int CREDIT_W      = 8,
    parameter int MAX_CREDIT    = 200,
    parameter int VEND_TICKS    = 3,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                coin_5,
    input  logic                coin_10,
    input  logic                coin_25,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                busy,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    // One extra bit so credit + coins can never wrap before the ceiling check.
    typedef logic [CREDIT_W:0] wide_t;

    localparam int TICK_MAX = (VEND_TICKS > TIMEOUT_TICKS) ? VEND_TICKS : TIMEOUT_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);

    localparam wide_t                MAX_W   = wide_t'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0]  PRICE_N = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0]  FIVE_N  = CREDIT_W'(5);
    localparam logic [TICK_W-1:0]    VEND_LAST = TICK_W'(VEND_TICKS - 1);

    state_t              state_r;
    logic [TICK_W-1:0]   tick_cnt;

    wide_t               coin_sum;
    wide_t               sum;
    logic                any_coin;
    logic                fits;
    logic                take_coin;
    logic [CREDIT_W-1:0] accepted;
    logic [CREDIT_W-1:0] due;
    logic                timeout_hit;

    assign state = state_r;

    // Coin arithmetic: summed coin value, ceiling check and post-coin credit.
    always_comb begin
        coin_sum  = (coin_5  ? wide_t'(5)  : wide_t'(0))
                  + (coin_10 ? wide_t'(10) : wide_t'(0))
                  + (coin_25 ? wide_t'(25) : wide_t'(0));
        any_coin  = coin_5 | coin_10 | coin_25;
        sum       = {1'b0, credit} + coin_sum;
        fits      = (sum <= MAX_W);
        take_coin = any_coin & fits;
        if (take_coin) begin
            accepted = CREDIT_W'(sum);
        end else begin
            accepted = credit;
        end
        due = accepted - PRICE_N;
`ifdef VEND_TIMEOUT_EN
        timeout_hit = tick && !take_coin && (tick_cnt == TICK_W'(TIMEOUT_TICKS - 1));
`else
        timeout_hit = 1'b0;
`endif
    end

    // Main FSM with registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            credit       <= '0;
            dispense     <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
            tick_cnt     <= '0;
        end else begin
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            case (state_r)
                IDLE: begin
                    tick_cnt    <= '0;
                    coin_reject <= any_coin & ~fits;
                    if (take_coin) begin
                        if (accepted >= PRICE_N) begin
                            state_r  <= VEND;
                            credit   <= due;
                            dispense <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state_r <= COLLECT;
                            credit  <= accepted;
                        end
                    end
                end
                COLLECT: begin
                    coin_reject <= any_coin & ~fits;
                    credit      <= accepted;
                    if (cancel) begin
                        // Same-cycle coin is still credited, then refunded.
                        state_r  <= CHANGE;
                        busy     <= 1'b1;
                        tick_cnt <= '0;
                    end else if (accepted >= PRICE_N) begin
                        state_r  <= VEND;
                        credit   <= due;
                        dispense <= 1'b1;
                        busy     <= 1'b1;
                        tick_cnt <= '0;
                    end else if (timeout_hit) begin
                        state_r  <= CHANGE;
                        busy     <= 1'b1;
                        tick_cnt <= '0;
                    end else begin
`ifdef VEND_TIMEOUT_EN
                        if (take_coin) begin
                            tick_cnt <= '0;
                        end else if (tick) begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
`else
                        tick_cnt <= '0;
`endif
                    end
                end
                VEND: begin
                    coin_reject <= any_coin;
                    if (tick) begin
                        if (tick_cnt == VEND_LAST) begin
                            dispense <= 1'b0;
                            tick_cnt <= '0;
                            if (credit != '0) begin
                                state_r <= CHANGE;
                            end else begin
                                state_r <= IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                CHANGE: begin
                    coin_reject <= any_coin;
                    tick_cnt    <= '0;
                    if (credit == '0) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else if (tick) begin
                        change_pulse <= 1'b1;
                        credit       <= credit - FIVE_N;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    credit   <= '0;
                    dispense <= 1'b0;
                    busy     <= 1'b0;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Main sequencing FSM for the vending machine.
- Accumulates coin credit and vends one item when credit reaches PRICE, then returns change one 5-unit coin at a time.
- Paced by the 1-cycle `tick` from the board's clock-enable generator (1 Hz on the FPGA board).
- Coin, cancel and tick inputs are already synchronised and debounced, one clk cycle wide.

Parameters:
- PRICE, 75, item price in 5-unit multiples (cents).
- CREDIT_W, 8, credit register width.
- MAX_CREDIT, 200, credit ceiling; coins that would exceed it are rejected.
- VEND_TICKS, 3, number of ticks `dispense` stays asserted.
- TIMEOUT_TICKS, 10, ticks without a coin before auto-refund (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- tick  in  1  1-cycle clock-enable pulse
- coin_5  in  1  5-unit coin pulse
- coin_10  in  1  10-unit coin pulse
- coin_25  in  1  25-unit coin pulse
- cancel  in  1  refund request pulse
- credit  out  CREDIT_W  current credit
- dispense  out  1  item motor drive
- change_pulse  out  1  one 5-unit coin returned, 1 cycle wide
- coin_reject  out  1  1-cycle pulse, coin(s) refused
- busy  out  1  high in VEND or CHANGE
- state  out  2  IDLE=0, COLLECT=1, VEND=2, CHANGE=3

Behaviour:
- reset low at a clk edge: state=IDLE, credit=0, dispense=0, change_pulse=0, coin_reject=0, busy=0, tick counters=0. Reset mid-vend or mid-change abandons the operation; no change is owed afterwards.
- coin_sum = 5·coin_5 + 10·coin_10 + 25·coin_25. Simultaneous coins are summed, max 40.
- Coin acceptance (IDLE or COLLECT only):
  - If credit + coin_sum ≤ MAX_CREDIT: next_credit = credit + coin_sum.
  - Otherwise all coins that cycle are rejected, coin_reject=1 for one cycle, credit unchanged.
  - Any coin in VEND or CHANGE is rejected with coin_reject=1.
- Arithmetic is done at CREDIT_W+1 bits so the overflow check cannot wrap.
- IDLE:
  - Accepted coin → COLLECT with credit=next_credit.
  - If next_credit ≥ PRICE, go directly to VEND with credit = next_credit − PRICE.
  - cancel is ignored.
- COLLECT, priority order each cycle:
  1. cancel → CHANGE; a same-cycle coin is still credited.
  2. next_credit ≥ PRICE → VEND, credit = next_credit − PRICE.
  3. Otherwise stay in COLLECT.
- VEND:
  - dispense=1 from the entry cycle.
  - A tick counter increments on each tick. On the VEND_TICKS-th tick, dispense drops the following cycle.
  - Exit → CHANGE if credit > 0, else IDLE.
  - cancel is ignored.
- CHANGE:
  - On each tick with credit ≥ 5: change_pulse=1 for one cycle, credit −= 5.
  - When credit = 0 → IDLE on the next cycle. Entry with credit=0 goes to IDLE immediately.
  - cancel is ignored.
- Latency: coin pulse at cycle N → credit updated at N+1. Vend entry is at N+1 when the threshold is met.
- tick coincident with a state entry does not count toward that state's tick counts.
- Invariant: credit is always a multiple of 5 and never exceeds MAX_CREDIT.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined:
  - In COLLECT, an idle-tick counter clears on every accepted coin and increments on each tick.
  - Reaching TIMEOUT_TICKS forces COLLECT → CHANGE (full refund).
  - cancel and a vend in the same cycle take priority over timeout.
- Undefined: no counter is built; COLLECT persists indefinitely.

Test Plan:
- Reset/basic vend: reset low 2 cycles, then coin_25 ×3 → credit 25, 50, then VEND; dispense high exactly 3 ticks; credit=0; then IDLE; no change_pulse.
- Overpay with change: coins 25, 25, 10, 25 (total 85) → VEND with credit=10; after dispense, 2 change_pulses on consecutive ticks; then IDLE, credit=0.
- Simultaneous coins: coin_5+coin_10+coin_25 in one cycle from IDLE → credit=40, state=COLLECT.
- Cancel: credit 35, then cancel → CHANGE; 7 change_pulses, one per tick; then IDLE. A coin during CHANGE gives coin_reject=1 and credit is unchanged.
- Overflow: with PRICE raised to 255, build credit 190, then coin_25 → coin_reject pulse, credit stays 190.
- Timeout (VEND_TIMEOUT_EN): coin_10, then 10 ticks with no coin → CHANGE, 2 change_pulses, then IDLE. Without the macro, state stays COLLECT after 20 ticks.
